gate_tt_sequencer: RTL and testbench

- Self-checking truth-table sequencer for any 2-input logic gate in the gate library, e.g. `nor_gate`.
- Walks the four input vectors on `a`/`b`, waits a fixed settle time, samples the gate output, compares it against an expected truth table, and reports pass/fail with an error count.
- Instantiated in synthesizable gate-level self-test wrappers and reused by gate benches in place of hand-written `#10` stimulus.

---
 rtl/gate_seq_pkg.sv | 31 +++
 rtl/gate_settle_timer.sv | 47 ++++
 rtl/gate_tt_sequencer.sv | 149 ++++++++++++++
 tb/tb_gate_tt_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_seq_pkg.sv
// Shared types and constants for the gate truth-table sequencer.
// Truth tables are indexed by {a,b}: bit 0 is a=0,b=0 and bit 3 is a=1,b=1.
package gate_seq_pkg;

  localparam int NUM_VEC = 4;
  localparam int IDX_W   = 2;
  localparam int ERR_W   = 3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = ERR_W'(NUM_VEC);

  // Named truth tables for the common 2-input gates
  localparam logic [NUM_VEC-1:0] TT_NOR  = 4'b0001;
  localparam logic [NUM_VEC-1:0] TT_AND  = 4'b1000;
  localparam logic [NUM_VEC-1:0] TT_OR   = 4'b1110;
  localparam logic [NUM_VEC-1:0] TT_XOR  = 4'b0110;
  localparam logic [NUM_VEC-1:0] TT_NAND = 4'b0111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } seq_state_e;

  // Expected gate output for a given vector index
  function automatic logic exp_bit(input logic [NUM_VEC-1:0] tt, input logic [IDX_W-1:0] idx);
    return tt[idx];
  endfunction

endpackage

// File: rtl/gate_settle_timer.sv
// Settle timer: counts cycles since the last clear and flags when the
// configured settle time has elapsed. Counts up from 0 and holds at the
// terminal value SETTLE_CYCLES-1, where expired is asserted.
module gate_settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic expired
);

  // A settle time of zero cannot be represented by the state machine
  // (SETTLE always lasts at least one cycle), so refuse to elaborate.
  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
      $error("gate_settle_timer: SETTLE_CYCLES must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] LAST = 4'(SETTLE_CYCLES - 1);

  logic [3:0] count_q;
  logic [3:0] count_d;

  // Next count: clear wins, otherwise advance until the terminal value
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 4'd0;
    end else if (count_q != LAST) begin
      count_d = count_q + 4'd1;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LAST);

endmodule

// File: rtl/gate_tt_sequencer.sv
// Truth-table sequencer for a 2-input gate: walks {a,b} through 00,01,10,11,
// lets each vector settle, samples gate_out and counts mismatches against
// EXP_TABLE. Optional first-error logging is enabled by defining
// GATE_SEQ_ERRLOG_EN (adds first_err_idx and err_seen ports).
module gate_tt_sequencer
  import gate_seq_pkg::*;
#(
  parameter logic [3:0] EXP_TABLE     = TT_NOR,
  parameter int         SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             gate_out,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic             pass,
`ifdef GATE_SEQ_ERRLOG_EN
  output logic [IDX_W-1:0] first_err_idx,
  output logic             err_seen,
`endif
  output logic [ERR_W-1:0] err_count
);

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic             pass_q, pass_d;
  logic             timer_clear;
  logic             timer_expired;
  logic             mismatch;

  // X/Z on gate_out must count as a mismatch, hence the case inequality
  assign mismatch = (gate_out !== exp_bit(EXP_TABLE, idx_q));

  // Timer only runs while a vector is settling; any other state holds it at 0
  assign timer_clear = (state_q != SETTLE);

  gate_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .expired(timer_expired)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SETTLE;
      SETTLE:  if (timer_expired) state_d = CHECK;
      CHECK:   state_d = (idx_q == LAST_IDX) ? DONE : SETTLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; vectors are only driven during a run
  always_comb begin
    busy = (state_q == SETTLE) || (state_q == CHECK);
    done = (state_q == DONE);
    a    = busy ? idx_q[1] : 1'b0;
    b    = busy ? idx_q[0] : 1'b0;
  end

  // Vector index, error count and pass flag updates
  always_comb begin
    idx_d       = idx_q;
    err_count_d = err_count_q;
    pass_d      = pass_q;
    if (state_q == IDLE && start) begin
      idx_d       = '0;
      err_count_d = '0;
      pass_d      = 1'b0;
    end else if (state_q == CHECK) begin
      if (mismatch && err_count_q != ERR_MAX) begin
        err_count_d = err_count_q + 3'd1;
      end
      // pass is settled on the final CHECK edge so it is valid alongside done
      if (idx_q == LAST_IDX) begin
        pass_d = (err_count_d == '0);
      end else begin
        idx_d = idx_q + 2'd1;
      end
    end
  end

  // Run-tracking registers
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      err_count_q <= '0;
      pass_q      <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      err_count_q <= err_count_d;
      pass_q      <= pass_d;
    end
  end

  assign pass      = pass_q;
  assign err_count = err_count_q;

`ifdef GATE_SEQ_ERRLOG_EN
  logic [IDX_W-1:0] first_err_idx_q, first_err_idx_d;
  logic             err_seen_q, err_seen_d;

  // Capture the index of the first mismatch of a run; later ones are ignored
  always_comb begin
    first_err_idx_d = first_err_idx_q;
    err_seen_d      = err_seen_q;
    if (state_q == IDLE && start) begin
      first_err_idx_d = '0;
      err_seen_d      = 1'b0;
    end else if (state_q == CHECK && mismatch && !err_seen_q) begin
      first_err_idx_d = idx_q;
      err_seen_d      = 1'b1;
    end
  end

  // First-error log registers
  always_ff @(posedge clk) begin
    if (rst) begin
      first_err_idx_q <= '0;
      err_seen_q      <= 1'b0;
    end else begin
      first_err_idx_q <= first_err_idx_d;
      err_seen_q      <= err_seen_d;
    end
  end

  assign first_err_idx = first_err_idx_q;
  assign err_seen      = err_seen_q;
`endif

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Scoreboard bench for gate_tt_sequencer: three instances (NOR defaults,
// NOR gate against the OR table, and SETTLE_CYCLES=1). Each run pushes the
// expected result and done cycle; per-instance monitors pop on done.
module tb_gate_tt_sequencer;
  import gate_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic const0_mode = 1'b0;

  logic a0, b0, busy0, done0, pass0, g0;
  logic a1, b1, busy1, done1, pass1, g1;
  logic a2, b2, busy2, done2, pass2, g2;
  logic [2:0] ec0, ec1, ec2;
`ifdef GATE_SEQ_ERRLOG_EN
  logic [1:0] fi0, fi1, fi2;
  logic       es0, es1, es2;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Gates under test: NOR, optionally stuck at 0 for instance 0
  assign g0 = const0_mode ? 1'b0 : ~(a0 | b0);
  assign g1 = ~(a1 | b1);
  assign g2 = ~(a2 | b2);

  gate_tt_sequencer dut0 (
    .clk(clk), .rst(rst), .start(start0), .gate_out(g0),
    .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
`ifdef GATE_SEQ_ERRLOG_EN
    .first_err_idx(fi0), .err_seen(es0),
`endif
    .err_count(ec0));

  gate_tt_sequencer #(.EXP_TABLE(TT_OR)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .gate_out(g1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
`ifdef GATE_SEQ_ERRLOG_EN
    .first_err_idx(fi1), .err_seen(es1),
`endif
    .err_count(ec1));

  gate_tt_sequencer #(.SETTLE_CYCLES(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .gate_out(g2),
    .a(a2), .b(b2), .busy(busy2), .done(done2), .pass(pass2),
`ifdef GATE_SEQ_ERRLOG_EN
    .first_err_idx(fi2), .err_seen(es2),
`endif
    .err_count(ec2));

  typedef struct {
    int err;
    int pas;
    int fidx;
    int seen;
    int cyc;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];
  exp_t e0, e1, e2;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t mk(input int err, input int pas, input int fidx, input int seen, input int c);
    exp_t e;
    e.err = err; e.pas = pas; e.fidx = fidx; e.seen = seen; e.cyc = c;
    return e;
  endfunction

  // Monitors: one transaction line per done pulse
  always @(negedge clk) begin
    if (done0) begin
      if (q0.size() == 0) chk("dut0 unexpected done", 1, 0);
      else begin
        e0 = q0.pop_front();
        $display("dut0 done @%0d err_count=%0d pass=%0d", cyc, ec0, pass0);
        chk("dut0 done cycle", cyc, e0.cyc);
        chk("dut0 err_count", int'(ec0), e0.err);
        chk("dut0 pass", int'(pass0), e0.pas);
        chk("dut0 busy at done", int'(busy0), 0);
`ifdef GATE_SEQ_ERRLOG_EN
        chk("dut0 first_err_idx", int'(fi0), e0.fidx);
        chk("dut0 err_seen", int'(es0), e0.seen);
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (done1) begin
      if (q1.size() == 0) chk("dut1 unexpected done", 1, 0);
      else begin
        e1 = q1.pop_front();
        $display("dut1 done @%0d err_count=%0d pass=%0d", cyc, ec1, pass1);
        chk("dut1 done cycle", cyc, e1.cyc);
        chk("dut1 err_count", int'(ec1), e1.err);
        chk("dut1 pass", int'(pass1), e1.pas);
`ifdef GATE_SEQ_ERRLOG_EN
        chk("dut1 first_err_idx", int'(fi1), e1.fidx);
        chk("dut1 err_seen", int'(es1), e1.seen);
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (done2) begin
      if (q2.size() == 0) chk("dut2 unexpected done", 1, 0);
      else begin
        e2 = q2.pop_front();
        $display("dut2 done @%0d err_count=%0d pass=%0d", cyc, ec2, pass2);
        chk("dut2 done cycle", cyc, e2.cyc);
        chk("dut2 err_count", int'(ec2), e2.err);
        chk("dut2 pass", int'(pass2), e2.pas);
      end
    end
  end

  // Bounded wait for a DUT's done, counted as a check
  task automatic wait_done0(input string name);
    int i;
    i = 0;
    while (!done0 && i < 40) begin
      @(negedge clk);
      i++;
    end
    chk(name, int'(done0), 1);
  endtask

  initial begin
    int n;
    int cnt;
    repeat (3) @(negedge clk);
    // Reset values
    chk("rst a", int'(a0), 0);
    chk("rst b", int'(b0), 0);
    chk("rst busy", int'(busy0), 0);
    chk("rst done", int'(done0), 0);
    chk("rst pass", int'(pass0), 0);
    chk("rst err_count", int'(ec0), 0);
`ifdef GATE_SEQ_ERRLOG_EN
    chk("rst first_err_idx", int'(fi0), 0);
    chk("rst err_seen", int'(es0), 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // 1: clean NOR run, vector sequence at 3-cycle spacing
    start0 = 1'b1;
    q0.push_back(mk(0, 1, 0, 0, cyc + 13));
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      start0 = 1'b0;
      chk($sformatf("dut0 a after edge %0d", j), int'(a0), (j / 3) >> 1);
      chk($sformatf("dut0 b after edge %0d", j), int'(b0), (j / 3) & 1);
      chk($sformatf("dut0 busy after edge %0d", j), int'(busy0), 1);
    end
    @(negedge clk);
    chk("dut0 done run1", int'(done0), 1);
    chk("dut0 a in DONE", int'(a0), 0);
    repeat (2) @(negedge clk);

    // 2: gate stuck at 0 -> only vector 0 fails
    const0_mode = 1'b1;
    start0 = 1'b1;
    q0.push_back(mk(1, 0, 0, 1, cyc + 13));
    @(negedge clk);
    start0 = 1'b0;
    wait_done0("dut0 stuck0 done seen");
    repeat (4) @(negedge clk);
    chk("dut0 err_count held in IDLE", int'(ec0), 1);
    chk("dut0 pass held in IDLE", int'(pass0), 0);

    // 3: reset during SETTLE of vector 2 (still stuck, so err_count is 1)
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (6) @(negedge clk);
    chk("dut0 err before abort", int'(ec0), 1);
    chk("dut0 idx2 a before abort", int'(a0), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort a", int'(a0), 0);
    chk("abort b", int'(b0), 0);
    chk("abort busy", int'(busy0), 0);
    chk("abort done", int'(done0), 0);
    chk("abort pass", int'(pass0), 0);
    chk("abort err_count", int'(ec0), 0);
    const0_mode = 1'b0;
    repeat (15) @(negedge clk);
    start0 = 1'b1;
    q0.push_back(mk(0, 1, 0, 0, cyc + 13));
    @(negedge clk);
    start0 = 1'b0;
    wait_done0("dut0 post-abort done seen");
    @(negedge clk);

    // 4: start while busy and on the done cycle are both ignored
    start0 = 1'b1;
    q0.push_back(mk(0, 1, 0, 0, cyc + 13));
    @(negedge clk);
    start0 = 1'b0;
    repeat (4) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_done0("dut0 busy-start done seen");
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (20) @(negedge clk);
    chk("dut0 idle after ignored starts", int'(busy0), 0);

    // 5: start held high -> back-to-back runs, done 14 cycles apart
    start0 = 1'b1;
    n = cyc;
    q0.push_back(mk(0, 1, 0, 0, n + 13));
    q0.push_back(mk(0, 1, 0, 0, n + 27));
    cnt = 0;
    for (int i = 0; i < 60 && cnt < 2; i++) begin
      @(negedge clk);
      if (done0) cnt++;
    end
    start0 = 1'b0;
    chk("dut0 held-start done count", cnt, 2);
    repeat (20) @(negedge clk);

    // 6: OR table against NOR gate -> every vector mismatches
    start1 = 1'b1;
    q1.push_back(mk(4, 0, 0, 1, cyc + 13));
    @(negedge clk);
    start1 = 1'b0;
    repeat (16) @(negedge clk);

    // 7: SETTLE_CYCLES=1 -> vectors every 2 cycles, done 8 after start
    start2 = 1'b1;
    q2.push_back(mk(0, 1, 0, 0, cyc + 9));
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      start2 = 1'b0;
      chk($sformatf("dut2 a after edge %0d", j), int'(a2), (j / 2) >> 1);
      chk($sformatf("dut2 b after edge %0d", j), int'(b2), (j / 2) & 1);
    end
    repeat (6) @(negedge clk);

    chk("dut0 scoreboard drained", q0.size(), 0);
    chk("dut1 scoreboard drained", q1.size(), 0);
    chk("dut2 scoreboard drained", q2.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
